// File: rtl/nf_router_pkg.sv
// Shared types and slave address map for the load/store router.
// The decoder and the control FSM both import these definitions.
`ifndef SLAVE_NUMBER
`define SLAVE_NUMBER 4
`endif

package nf_router_pkg;

    localparam int SLAVE_N   = `SLAVE_NUMBER;
    localparam int TIMEOUT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERROR,
        ST_DONE
    } state_e;

    // Map: RAM, GPIO, PWM, slave3.
    localparam logic [31:0] SLAVE_BASE [SLAVE_N] = '{
        32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000
    };
    localparam logic [31:0] SLAVE_MASK [SLAVE_N] = '{
        32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000
    };

endpackage

// File: rtl/nf_router_dec.sv
// Combinational address decoder: one-hot hit vector, lowest index wins.
// Zero latency, no backpressure; unmapped is high when no slave matches.
module nf_router_dec
    import nf_router_pkg::*;
(
    input  logic [31:0]        addr,
    output logic [SLAVE_N-1:0] hit,
    output logic               unmapped
);

    always_comb begin
        hit = '0;
        // Walk downward so the lowest matching index is the last one written.
        for (int i = SLAVE_N - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        unmapped = ~|hit;
    end

endmodule

// File: rtl/nf_router_ctrl.sv
// Request-side router control: decode, single outstanding slave request, timeout/error ack.
// Zero-wait slave acks in the cycle after req_m is sampled; next request taken 3 edges later.
module nf_router_ctrl
    import nf_router_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        addr_m,
    input  logic               we_m,
    input  logic               req_m,
    output logic               req_ack_m,
    output logic               err_m,
    output logic               busy,
    output logic [SLAVE_N-1:0] slave_sel_rd,
    output logic [SLAVE_N-1:0] req_s,
    output logic [31:0]        addr_s,
    output logic               we_s,
    input  logic [SLAVE_N-1:0] req_ack_s
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [SLAVE_N-1:0]   SEL_RST  = {{(SLAVE_N-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [SLAVE_N-1:0]   sel_q, sel_d;
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic [SLAVE_N-1:0]   dec_hit;
    logic                 dec_unmapped;
    logic                 ack_hit;

    nf_router_dec u_dec (
        .addr     (addr_m),
        .hit      (dec_hit),
        .unmapped (dec_unmapped)
    );

    assign ack_hit = |(req_ack_s & sel_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        req_s     = '0;
        req_ack_m = 1'b0;
        err_m     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_m) begin
                    addr_d = addr_m;
                    we_d   = we_m;
                    if (dec_unmapped) begin
                        state_d = ST_ERROR;
                    end else begin
                        sel_d   = dec_hit;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                req_s     = sel_q;
                req_ack_m = ack_hit;
                // An ack on the final counted cycle still wins over the timeout.
                if (ack_hit) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERROR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERROR: begin
                req_ack_m = 1'b1;
                err_m     = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_RST;
            addr_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign slave_sel_rd = sel_q;
    assign addr_s       = addr_q;
    assign we_s         = we_q;

endmodule

// File: tb/tb_nf_router_ctrl.sv
// Directed bench for nf_router_ctrl: reset, zero-wait, wait states, unmapped, timeout, spurious ack, mid-access reset.
module tb_nf_router_ctrl;
    import nf_router_pkg::*;

    logic               clk = 1'b0;
    logic               resetn;
    logic [31:0]        addr_m;
    logic               we_m;
    logic               req_m;
    logic               req_ack_m;
    logic               err_m;
    logic               busy;
    logic [SLAVE_N-1:0] slave_sel_rd;
    logic [SLAVE_N-1:0] req_s;
    logic [31:0]        addr_s;
    logic               we_s;
    logic [SLAVE_N-1:0] req_ack_s;

    int n_tests = 0;
    int n_fail  = 0;

    nf_router_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .addr_m       (addr_m),
        .we_m         (we_m),
        .req_m        (req_m),
        .req_ack_m    (req_ack_m),
        .err_m        (err_m),
        .busy         (busy),
        .slave_sel_rd (slave_sel_rd),
        .req_s        (req_s),
        .addr_s       (addr_s),
        .we_s         (we_s),
        .req_ack_s    (req_ack_s)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are changed afterwards, outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_m = 1'b1; addr_m = 32'h0001_0004; we_m = 1'b1; req_ack_s = '0;
        repeat (3) step();
        #1;
        n_tests++; if (req_s !== 4'b0000) begin n_fail++; $display("FAIL reset_req_s got %b exp 0000", req_s); end
        n_tests++; if (slave_sel_rd !== 4'b0001) begin n_fail++; $display("FAIL reset_sel got %b exp 0001", slave_sel_rd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (req_ack_m !== 1'b0 || err_m !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b/%b exp 0/0", req_ack_m, err_m); end
        n_tests++; if (addr_s !== 32'h0 || we_s !== 1'b0) begin n_fail++; $display("FAIL reset_addr_we got %h/%b exp 0/0", addr_s, we_s); end
        req_m = 1'b0; resetn = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        addr_m = 32'h0001_0004; we_m = 1'b0; req_m = 1'b1;
        step();                                   // edge N
        req_ack_s = 4'b0010; #1;                  // cycle N+1
        n_tests++; if (req_s !== 4'b0010) begin n_fail++; $display("FAIL zw_req_s got %b exp 0010", req_s); end
        n_tests++; if (req_ack_m !== 1'b1 || err_m !== 1'b0) begin n_fail++; $display("FAIL zw_ack got %b/%b exp 1/0", req_ack_m, err_m); end
        n_tests++; if (slave_sel_rd !== 4'b0010) begin n_fail++; $display("FAIL zw_sel got %b exp 0010", slave_sel_rd); end
        step();                                   // DONE: a new request must be ignored here
        req_ack_s = '0; addr_m = 32'h0000_0020; we_m = 1'b0; req_m = 1'b1; #1;
        n_tests++; if (busy !== 1'b1 || req_s !== 4'b0000 || req_ack_m !== 1'b0) begin n_fail++; $display("FAIL zw_done got busy=%b req_s=%b ack=%b exp 1/0000/0", busy, req_s, req_ack_m); end
        step(); #1;                               // IDLE
        n_tests++; if (busy !== 1'b0 || req_s !== 4'b0000) begin n_fail++; $display("FAIL zw_idle got busy=%b req_s=%b exp 0/0000", busy, req_s); end
        step(); #1;                               // edge N+3 accepted the next request
        n_tests++; if (req_s !== 4'b0001 || addr_s !== 32'h0000_0020 || slave_sel_rd !== 4'b0001) begin n_fail++; $display("FAIL zw_next got req_s=%b addr=%h sel=%b exp 0001/00000020/0001", req_s, addr_s, slave_sel_rd); end
        req_ack_s = 4'b0001; #1;
        n_tests++; if (req_ack_m !== 1'b1) begin n_fail++; $display("FAIL zw_next_ack got %b exp 1", req_ack_m); end
        step(); req_ack_s = '0; req_m = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        int acks;
        logic req_ok;
        acks = 0; req_ok = 1'b1;
        addr_m = 32'h0000_0010; we_m = 1'b1; req_m = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            req_ack_s = (k == 5) ? 4'b0001 : 4'b0000; #1;
            if (req_s !== 4'b0001) req_ok = 1'b0;
            if (req_ack_m === 1'b1) acks++;
            if (k == 5) begin
                n_tests++; if (we_s !== 1'b1 || addr_s !== 32'h0000_0010) begin n_fail++; $display("FAIL ws_regs got we=%b addr=%h exp 1/00000010", we_s, addr_s); end
            end
            step();
        end
        req_ack_s = '0; req_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1; if (req_ack_m === 1'b1) acks++;
            if (req_s !== 4'b0000) req_ok = 1'b0;
            step();
        end
        n_tests++; if (req_ok !== 1'b1) begin n_fail++; $display("FAIL ws_req_s got held=%b exp 1", req_ok); end
        n_tests++; if (acks != 1) begin n_fail++; $display("FAIL ws_ack_pulses got %0d exp 1", acks); end
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ws_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_unmapped();
        addr_m = 32'h8000_0000; we_m = 1'b0; req_m = 1'b1;
        step(); #1;
        n_tests++; if (req_s !== 4'b0000) begin n_fail++; $display("FAIL um_req_s got %b exp 0000", req_s); end
        n_tests++; if (req_ack_m !== 1'b1 || err_m !== 1'b1) begin n_fail++; $display("FAIL um_ack got %b/%b exp 1/1", req_ack_m, err_m); end
        n_tests++; if (slave_sel_rd !== 4'b0001) begin n_fail++; $display("FAIL um_sel got %b exp 0001", slave_sel_rd); end
        req_m = 1'b0;
        step(); #1;
        n_tests++; if (req_ack_m !== 1'b0 || err_m !== 1'b0) begin n_fail++; $display("FAIL um_done got %b/%b exp 0/0", req_ack_m, err_m); end
        step();
    endtask

    task automatic test_timeout(input bit late_ack);
        logic ok;
        ok = 1'b1;
        addr_m = 32'h0002_0040; we_m = 1'b0; req_m = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            req_ack_s = (late_ack && k == 15) ? 4'b0100 : 4'b0000; #1;
            if (req_s !== 4'b0100) ok = 1'b0;
            if (k < 15 && req_ack_m !== 1'b0) ok = 1'b0;
            if (k == 15 && late_ack) begin
                n_tests++; if (req_ack_m !== 1'b1 || err_m !== 1'b0) begin n_fail++; $display("FAIL to_late_ack got %b/%b exp 1/0", req_ack_m, err_m); end
            end
            step();
        end
        req_ack_s = '0; #1;
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_access late=%0d got ok=%b exp 1", late_ack, ok); end
        if (!late_ack) begin
            n_tests++; if (req_s !== 4'b0000 || req_ack_m !== 1'b1 || err_m !== 1'b1) begin n_fail++; $display("FAIL to_error got req_s=%b ack=%b err=%b exp 0000/1/1", req_s, req_ack_m, err_m); end
            req_m = 1'b0; step(); #1;
        end else begin
            req_m = 1'b0;
        end
        n_tests++; if (busy !== 1'b1 || req_ack_m !== 1'b0 || err_m !== 1'b0) begin n_fail++; $display("FAIL to_done late=%0d got busy=%b ack=%b err=%b exp 1/0/0", late_ack, busy, req_ack_m, err_m); end
        step(); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle late=%0d got busy=%b exp 0", late_ack, busy); end
    endtask

    task automatic test_spurious_and_reset();
        addr_m = 32'h0001_0000; we_m = 1'b1; req_m = 1'b1;
        step();
        req_ack_s = 4'b1000; #1;
        n_tests++; if (req_s !== 4'b0010 || req_ack_m !== 1'b0) begin n_fail++; $display("FAIL sp_ignored got req_s=%b ack=%b exp 0010/0", req_s, req_ack_m); end
        step();
        req_ack_s = '0; resetn = 1'b0; #1;
        n_tests++; if (busy !== 1'b1 || req_ack_m !== 1'b0) begin n_fail++; $display("FAIL rst_pre got busy=%b ack=%b exp 1/0", busy, req_ack_m); end
        step();
        req_ack_s = 4'b1111; #1;
        n_tests++; if (busy !== 1'b0 || req_s !== 4'b0000 || req_ack_m !== 1'b0 || err_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid got busy=%b req_s=%b ack=%b err=%b exp 0/0000/0/0", busy, req_s, req_ack_m, err_m); end
        n_tests++; if (slave_sel_rd !== 4'b0001 || addr_s !== 32'h0 || we_s !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs got sel=%b addr=%h we=%b exp 0001/0/0", slave_sel_rd, addr_s, we_s); end
        req_m = 1'b0; resetn = 1'b1;
        step(); #1;
        n_tests++; if (req_ack_m !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored got ack=%b busy=%b exp 0/0", req_ack_m, busy); end
        req_ack_s = '0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_unmapped();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_spurious_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
